// File: rtl/video_axis_capture.sv
// video_axis_capture: frames pixel-bus video into an AXI-Stream through a first-word fall-through FIFO
module video_axis_capture #(
  parameter int   H_VISIBLE  = 640,
  parameter int   V_VISIBLE  = 480,
  parameter int   FIFO_DEPTH = 16,
  parameter logic VSYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic        blank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        capture_en,
  output logic [31:0] tdata,
  output logic        tlast,
  output logic        tvalid,
  input  logic        tready,
  output logic        overflow,
  output logic [7:0]  frames_dropped
);
  localparam int NPIX = H_VISIBLE * V_VISIBLE;
  localparam int CW = NPIX > 1 ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_PX = CW'(NPIX - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  typedef enum logic [1:0] {WAIT_VS, CAPTURE, TERM} state_t;
  state_t state, state_nx;
  logic vs_prev, frame_edge, last_px;
  logic [CW-1:0] cnt;
  logic cnt_clr, cnt_inc, ovf_set, drop;
  logic push, pop, full, empty;
  logic [32:0] push_word, head;
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic unused_hsync;
  assign unused_hsync = hsync_in;
  assign frame_edge = (vsync_in == VSYNC_POL) && (vs_prev != VSYNC_POL);
  assign last_px = cnt == LAST_PX;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = mem[rd_ptr[AW-1:0]];
  assign tvalid = !empty;
  assign tdata = empty ? '0 : head[31:0];
  assign tlast = !empty && head[32];
  assign pop = tvalid && tready;
  always_comb begin
    state_nx = state;
    push = 1'b0;
    push_word = '0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    ovf_set = 1'b0;
    drop = 1'b0;
    case (state)
      WAIT_VS: begin
        if (frame_edge && capture_en) begin
          state_nx = CAPTURE;
          cnt_clr = 1'b1;
        end
      end
      CAPTURE: begin
        // a new frame boundary beats any pixel in the same cycle
        if (frame_edge) begin
          state_nx = TERM;
          drop = 1'b1;
        end else if (!blank_in && full) begin
          state_nx = TERM;
          ovf_set = 1'b1;
          drop = 1'b1;
        end else if (!blank_in) begin
          push = 1'b1;
          push_word = {last_px, 8'h00, blue_in, green_in, red_in};
          cnt_inc = 1'b1;
          state_nx = last_px ? WAIT_VS : CAPTURE;
        end
      end
      TERM: begin
        if (!full) begin
          push = 1'b1;
          push_word = {1'b1, 32'h0};
          state_nx = WAIT_VS;
        end
      end
      default: state_nx = WAIT_VS;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_VS;
      vs_prev <= ~VSYNC_POL;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      frames_dropped <= '0;
    end else begin
      state <= state_nx;
      vs_prev <= vsync_in;
      cnt <= cnt_clr ? '0 : cnt_inc ? cnt + CNT_ONE : cnt;
      wr_ptr <= push ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PTR_ONE : rd_ptr;
      overflow <= overflow | ovf_set;
      if (drop && frames_dropped != 8'hff) frames_dropped <= frames_dropped + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_word;
  end
endmodule

// File: tb/tb_video_axis_capture.sv
// tb_video_axis_capture: directed table and sequence checks of video capture framing and FIFO behaviour
module tb_video_axis_capture;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] red_in = '0, green_in = '0, blue_in = '0;
  logic blank_in = 1'b1, hsync_in = 1'b0, vsync_in = 1'b1, capture_en = 1'b1, tready = 1'b1;
  logic [31:0] tdata;
  logic tlast, tvalid, overflow;
  logic [7:0] frames_dropped;
  int total = 0, passed = 0, cyc = 0;
  bit rnd = 1'b0;
  logic [32:0] got[$], ex[$];
  logic held = 1'b0;
  logic [32:0] held_w = '0;
  typedef struct {
    logic vs, blank, rdy, en;
    logic [7:0] r;
    logic ev;
    logic [31:0] ed;
    logic el;
  } vec_t;
  vec_t tv[12];

  video_axis_capture #(.H_VISIBLE(4), .V_VISIBLE(2), .FIFO_DEPTH(4), .VSYNC_POL(1'b0)) dut (
    .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .capture_en(capture_en),
    .tdata(tdata), .tlast(tlast), .tvalid(tvalid), .tready(tready),
    .overflow(overflow), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  always @(negedge clk) begin
    if (held) check("hold_stable", {tvalid, tlast, tdata}, {1'b1, held_w});
    if (tvalid && tready && !rst) got.push_back({tlast, tdata});
    held <= tvalid && !tready && !rst;
    held_w <= {tlast, tdata};
  end

  function automatic logic [32:0] pw(input logic [7:0] r, input logic l);
    return {l, 8'h00, r + 8'h20, r + 8'h10, r};
  endfunction

  task automatic step();
    if (rnd) tready = cyc[0] ? 1'b1 : 1'($urandom_range(0, 1));
    hsync_in = ~hsync_in;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic vs_edge();
    vsync_in = 1'b0;
    blank_in = 1'b1;
    step();
    vsync_in = 1'b1;
    step();
  endtask

  task automatic pix(input logic [7:0] r);
    blank_in = 1'b0;
    red_in = r;
    green_in = r + 8'h10;
    blue_in = r + 8'h20;
    step();
    blank_in = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync_in = 1'b1;
    blank_in = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 300 && got.size() < n; i++) step();
    repeat (6) step();
  endtask

  task automatic cmp_stream(input string name);
    check({name, "_count"}, 64'(got.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < got.size(); i++)
      check($sformatf("%s_word%0d", name, i), 64'(got[i]), 64'(ex[i]));
  endtask

  task automatic frame_exp(input int n, input logic last_on_n);
    ex.delete();
    for (int i = 0; i < n; i++) ex.push_back(pw(8'(i), last_on_n && i == n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 32'h00000000, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd0,  1'b1, 32'h00201000, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd1,  1'b1, 32'h00211101, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd2,  1'b1, 32'h00221202, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd3,  1'b1, 32'h00231303, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd4,  1'b1, 32'h00241404, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd5,  1'b1, 32'h00251505, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd6,  1'b1, 32'h00261606, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd7,  1'b1, 32'h00271707, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd9,  1'b0, 32'h00000000, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd10, 1'b0, 32'h00000000, 1'b0};
    tv[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 32'h00000000, 1'b0};
    step();
    step();
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_frames_dropped", 64'(frames_dropped), 64'(0));
    rst = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      vsync_in = tv[i].vs;
      blank_in = tv[i].blank;
      tready = tv[i].rdy;
      capture_en = tv[i].en;
      red_in = tv[i].r;
      green_in = tv[i].r + 8'h10;
      blue_in = tv[i].r + 8'h20;
      step();
      check($sformatf("vec%0d", i), {tvalid, tlast, tdata}, {tv[i].ev, tv[i].el, tv[i].ed});
    end
    check("nom_overflow", 64'(overflow), 64'(0));
    check("nom_frames_dropped", 64'(frames_dropped), 64'(0));

    do_reset();
    got.delete();
    tready = 1'b0;
    vs_edge();
    for (int i = 0; i < 5; i++) pix(8'(i));
    check("bp_overflow", 64'(overflow), 64'(1));
    check("bp_frames_dropped", 64'(frames_dropped), 64'(1));
    check("bp_head", {tvalid, tlast, tdata}, {1'b1, pw(8'd0, 1'b0)});
    for (int i = 5; i < 8; i++) pix(8'(i));
    tready = 1'b1;
    frame_exp(4, 1'b0);
    ex.push_back({1'b1, 32'h0});
    drain(5);
    cmp_stream("bp");

    do_reset();
    got.delete();
    tready = 1'b1;
    vs_edge();
    for (int i = 0; i < 5; i++) pix(8'(i));
    vs_edge();
    for (int i = 10; i < 18; i++) pix(8'(i));
    frame_exp(5, 1'b0);
    ex.push_back({1'b1, 32'h0});
    drain(6);
    cmp_stream("short");
    check("short_frames_dropped", 64'(frames_dropped), 64'(1));
    check("short_overflow", 64'(overflow), 64'(0));

    do_reset();
    got.delete();
    capture_en = 1'b0;
    vs_edge();
    for (int i = 0; i < 8; i++) pix(8'(i));
    repeat (3) step();
    check("en_off_words", 64'(got.size()), 64'(0));
    check("en_off_tvalid", 64'(tvalid), 64'(0));
    capture_en = 1'b1;
    vs_edge();
    for (int i = 0; i < 4; i++) pix(8'(i));
    capture_en = 1'b0;
    for (int i = 4; i < 8; i++) pix(8'(i));
    capture_en = 1'b1;
    frame_exp(8, 1'b1);
    drain(8);
    cmp_stream("en_toggle");
    check("en_frames_dropped", 64'(frames_dropped), 64'(0));

    do_reset();
    got.delete();
    tready = 1'b0;
    pix(8'd99);
    check("pre_boundary_tvalid", 64'(tvalid), 64'(0));
    vs_edge();
    for (int i = 0; i < 3; i++) pix(8'(i));
    check("queued_tvalid", 64'(tvalid), 64'(1));
    rst = 1'b1;
    step();
    check("mid_rst_tvalid", 64'(tvalid), 64'(0));
    check("mid_rst_out", {tlast, tdata}, 64'(0));
    check("mid_rst_counters", {overflow, frames_dropped}, 64'(0));
    rst = 1'b0;
    tready = 1'b1;
    got.delete();
    vs_edge();
    for (int i = 0; i < 8; i++) pix(8'(i));
    frame_exp(8, 1'b1);
    drain(8);
    cmp_stream("after_rst");

    do_reset();
    got.delete();
    rnd = 1'b1;
    vs_edge();
    for (int i = 0; i < 8; i++) begin
      pix(8'(i));
      repeat (3) step();
    end
    frame_exp(8, 1'b1);
    drain(8);
    rnd = 1'b0;
    tready = 1'b1;
    cmp_stream("rnd");
    check("rnd_overflow", 64'(overflow), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/video_axis_capture.md
VIDEO_AXIS_CAPTURE -- requirements
Module: video_axis_capture

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, output FIFO entries; power of two, minimum 4.
REQ-004 Parameter VSYNC_POL, default 1'b0, active level of vsync_in.
REQ-005 clk  input  1  pixel clock; one pixel per cycle; the block's only clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 red_in / green_in / blue_in  input  8 each  pixel colour components.
REQ-008 blank_in  input  1  1 = blanking, 0 = active pixel.
REQ-009 hsync_in  input  1  horizontal sync; accepted, not used for framing.
REQ-010 vsync_in  input  1  vertical sync; polarity per VSYNC_POL.
REQ-011 capture_en  input  1  1 = capture frames; sampled only at frame boundaries.
REQ-012 tdata  output  32  AXI-Stream data {8'h00, blue, green, red}: red [7:0], green [15:8], blue [23:16].
REQ-013 tlast  output  1  marks the final word of a frame or of a truncated frame.
REQ-014 tvalid  output  1  AXI-Stream valid.
REQ-015 tready  input  1  AXI-Stream ready from downstream (DMA S2MM).
REQ-016 overflow  output  1  sticky; 1 once any pixel has been lost to a full FIFO.
REQ-017 frames_dropped  output  8  count of truncated frames, saturating at 255.

Function
REQ-018 Frame boundary = vsync assert edge: vsync_in equals VSYNC_POL in the current cycle and did not in the previous cycle; the previous-value register resets to ~VSYNC_POL.
REQ-019 FSM states: WAIT_VS, CAPTURE, TERM.
REQ-020 WAIT_VS: no pushes; on a frame boundary with capture_en=1 -> CAPTURE, pixel counter cleared to 0.
REQ-021 CAPTURE, blank_in=0, FIFO not full: push {pixel, tlast=0} and increment the counter; the push for pixel H_VISIBLE*V_VISIBLE-1 carries tlast=1 and the FSM goes to WAIT_VS.
REQ-022 CAPTURE, blank_in=0, FIFO full: the pixel is discarded, overflow is set, and the FSM goes to TERM.
REQ-023 CAPTURE, frame boundary before the last pixel (short frame): the FSM goes to TERM.
REQ-024 TERM pushes one word 32'h0 with tlast=1 in the first cycle the FIFO is not full, then goes to WAIT_VS; frames_dropped increments on every entry to TERM; active pixels seen in TERM are discarded.
REQ-025 After a full frame, extra active pixels before the next frame boundary are ignored (WAIT_VS).
REQ-026 capture_en deassertion mid-frame has no effect until the current frame ends.
REQ-027 Pixel counter width = clog2(H_VISIBLE*V_VISIBLE); it never wraps within a frame.
REQ-028 FIFO is first-word fall-through:
- tvalid = not empty.
- tdata/tlast are the head entry.
- A pop occurs on tvalid & tready.
REQ-029 Latency: a pixel pushed at edge N into an empty FIFO gives tvalid=1 with that pixel in cycle N+1.
REQ-030 Full is evaluated from the occupancy before the edge; a simultaneous pop does not make room for a same-cycle push.
REQ-031 Simultaneous push and pop when not full and not empty: occupancy is unchanged and ordering is preserved.
REQ-032 tdata and tlast hold stable while tvalid=1 and tready=0; tvalid never drops without a pop.
REQ-033 hsync_in is ignored; blank_in alone qualifies pixels.

Reset
REQ-034 rst=1 at a clock edge sets:
- FSM to WAIT_VS;
- FIFO empty, so tvalid=0 in the following cycle;
- tlast=0, tdata=0, overflow=0, frames_dropped=0, pixel counter 0.
REQ-035 Reset mid-frame or mid-stream discards FIFO contents; no partial-frame terminator is emitted.
REQ-036 After reset, capture begins only at the next frame boundary.

Verification (H_VISIBLE=4, V_VISIBLE=2, FIFO_DEPTH=4, VSYNC_POL=0 unless stated)
REQ-037 Nominal: tready=1, one frame of 8 active pixels red=0..7 -> 8 words 0x000000_00..07 in order; tlast only on the word with red=7; overflow=0.
REQ-038 Backpressure: tready=0 for the whole frame -> 4 words stored; 5th active pixel -> overflow=1, frames_dropped=1; after tready=1, output is 4 pixel words then 32'h0 with tlast=1.
REQ-039 Short frame: vsync edge after 5 pixels -> words 0..4 then 32'h0 with tlast=1; frames_dropped=1; the next frame is not captured.
REQ-040 capture_en=0 at the frame boundary -> no output for that frame; capture_en toggling mid-frame does not truncate the frame in progress.
REQ-041 rst pulsed with 3 words queued and tready=0 -> tvalid=0 the cycle after reset; counters 0; the next full frame is emitted intact.
REQ-042 Stability check: random tready throughout a frame -> tdata/tlast never change while tvalid=1 and tready=0; all 8 words arrive in order.
